// File: rtl/mmap_io_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmap_io_pkg
// Description : Register map, STATUS bit positions and counter limit shared
//               by the memory-mapped I/O register block.
// Revision    : 1.0 - initial release
// ============================================================================
package mmap_io_pkg;

  typedef logic [31:0] word_t;

  // Register word indices on sel
  localparam logic [3:0] REG_STATUS   = 4'd0;
  localparam logic [3:0] REG_RXDATA   = 4'd1;
  localparam logic [3:0] REG_TXDATA   = 4'd2;
  localparam logic [3:0] REG_CTRCLR   = 4'd3;
  localparam logic [3:0] REG_CTR_BASE = 4'd4;

  // STATUS bit positions
  localparam int STAT_TX_EMPTY    = 0;
  localparam int STAT_RX_NONEMPTY = 1;
  localparam int STAT_RX_OVF      = 2;
  localparam int STAT_RX_CNT_LSB  = 8;

  // Upper bound on the number of event counters
  localparam int MAX_CTRS = 8;

endpackage
`default_nettype wire

// File: rtl/mmap_io_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : mmap_io_regs_if
// Description : CPU load/store bus into the memory-mapped I/O registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmap_io_regs_if;
  logic [3:0]  sel;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output sel, rd_en, wr_en, wr_data, input rd_data);
  modport slave  (input sel, rd_en, wr_en, wr_data, output rd_data);
endinterface
`default_nettype wire

// File: rtl/mmap_io_regs_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_byte_fifo
// Description : Byte FIFO with occupancy count; push/pop are ignored when
//               full/empty respectively.
// Revision    : 1.0 - initial release
// ============================================================================
module io_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [7:0]               din,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; simultaneous push/pop leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  // Storage needs no reset: pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mmap_io_regs.sv
`default_nettype none
// ============================================================================
// Module      : mmap_io_regs
// Description : UART status, RX FIFO, TX holding register and event counters
//               behind a registered-read memory-mapped register interface.
// Revision    : 1.0 - initial release
// ============================================================================
module mmap_io_regs
  import mmap_io_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int NUM_CTRS = 2
) (
  input  wire logic                clk,
  input  wire logic                rst,
  mmap_io_regs_if.slave            bus,
  input  wire logic [7:0]          rx_data,
  input  wire logic                rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  wire logic                tx_ready,
  input  wire logic [NUM_CTRS-1:0] ctr_event
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          rx_pop;
  logic          ovf_q, ovf_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  word_t         rd_data_q, rd_data_d;
  word_t         status_w;
  word_t         ctr_vals [NUM_CTRS];
  logic          ctr_clr;
  logic          tx_wr, tx_hs, tx_load;
  logic          unused_ok;

  assign unused_ok = ^{bus.wr_data[31:8], ctr_event[0]};

  assign rx_pop  = bus.rd_en && (bus.sel == REG_RXDATA) && !fifo_empty;
  assign ctr_clr = bus.wr_en && (bus.sel == REG_CTRCLR);
  assign tx_wr   = bus.wr_en && (bus.sel == REG_TXDATA);
  assign tx_hs   = tx_valid_q && tx_ready;
  assign tx_load = tx_wr && (!tx_valid_q || tx_hs);

  io_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rx_ready    = !fifo_full;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign bus.rd_data = rd_data_q;

  // Free-running cycle counter at index 0, event counters above it
  for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
    logic  inc;
    word_t ctr_q, ctr_d;
    if (i == 0) begin : g_cycle
      assign inc = 1'b1;
    end else begin : g_event
      assign inc = ctr_event[i];
    end
    // Clear beats a same-cycle increment
    always_comb ctr_d = ctr_clr ? '0 : ctr_q + 32'(inc);
    // Counter register
    always_ff @(posedge clk) ctr_q <= rst ? '0 : ctr_d;
    assign ctr_vals[i] = ctr_q;
  end

  // Sticky overflow, TX holding register and assembled STATUS word
  always_comb begin
    ovf_d = ovf_q;
    if (bus.rd_en && (bus.sel == REG_STATUS)) ovf_d = 1'b0;
    if (rx_valid && fifo_full)                ovf_d = 1'b1;

    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_hs) tx_valid_d = 1'b0;
    if (tx_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.wr_data[7:0];
    end

    status_w                             = '0;
    status_w[STAT_TX_EMPTY]              = !tx_valid_q;
    status_w[STAT_RX_NONEMPTY]           = !fifo_empty;
    status_w[STAT_RX_OVF]                = ovf_q;
    status_w[STAT_RX_CNT_LSB +: CW]      = fifo_count;
  end

  // Read mux; rd_data holds when no read is issued
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = '0;
      case (bus.sel)
        REG_STATUS: rd_data_d = status_w;
        REG_RXDATA: rd_data_d = fifo_empty ? '0 : {24'b0, fifo_dout};
        default: begin
          for (int i = 0; i < NUM_CTRS; i++) begin
            if (bus.sel == REG_CTR_BASE + 4'(i)) rd_data_d = ctr_vals[i];
          end
        end
      endcase
    end
  end

  // Register state
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      ovf_q      <= ovf_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rd_data_q  <= rd_data_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mmap_io_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmap_io_regs
// Description : Directed bench for mmap_io_regs with a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmap_io_regs;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] ctr_event;

  always #5 clk = ~clk;

  mmap_io_regs_if bus();

  mmap_io_regs #(.RX_DEPTH(8), .NUM_CTRS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ctr_event (ctr_event)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        rd_pend = 1'b0;

  // A read issued at this edge produces rd_data after it
  always @(posedge clk) rd_pend <= bus.rd_en;

  // Monitor: compare each read result against the queued expectation
  always @(negedge clk) begin
    if (rd_pend) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read: got %h, nothing expected", bus.rd_data);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.rd_data === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, bus.rd_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic rd(input logic [3:0] s, input logic [31:0] e, input string nm);
    bus.sel   = s;
    bus.rd_en = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] s, input logic [31:0] d);
    bus.sel     = s;
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    rx_data     = '0;
    rx_valid    = 1'b0;
    tx_ready    = 1'b0;
    ctr_event   = '0;
    bus.sel     = '0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    rd(4'd0, 32'h0000_0001, "rst_status");
    rd(4'd4, 32'd1, "ctr0_second_read");

    // RX FIFO ordering and empty read
    rx_valid = 1'b1;
    rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_data = 8'h43; tick();
    rx_valid = 1'b0;
    rd(4'd0, 32'h0000_0303, "status_3bytes");
    rd(4'd1, 32'h41, "rx_0x41");
    rd(4'd1, 32'h42, "rx_0x42");
    rd(4'd1, 32'h43, "rx_0x43");
    rd(4'd1, 32'h0, "rx_empty_read");
    rd(4'd0, 32'h0000_0001, "status_drained");

    // Overflow: ninth byte is dropped
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'(i + 16);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx_ready_full", 32'(rx_ready), 32'd0);
    rd(4'd0, 32'h0000_0807, "status_ovf_set");
    rd(4'd0, 32'h0000_0803, "status_ovf_cleared");
    for (int i = 0; i < 8; i++) rd(4'd1, 32'(i + 16), "rx_drain");
    chk("rx_ready_drained", 32'(rx_ready), 32'd1);

    // TX holding register
    wr(4'd2, 32'h55);
    chk("tx_valid_load", 32'(tx_valid), 32'd1);
    chk("tx_data_load", 32'(tx_data), 32'h55);
    wr(4'd2, 32'h66);
    chk("tx_data_drop", 32'(tx_data), 32'h55);
    rd(4'd0, 32'h0000_0000, "status_tx_full");
    tx_ready = 1'b1;
    wr(4'd2, 32'h77);
    tx_ready = 1'b0;
    chk("tx_data_reload", 32'(tx_data), 32'h77);
    chk("tx_valid_reload", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_valid_done", 32'(tx_valid), 32'd0);

    // Event counter and clear
    for (int i = 0; i < 5; i++) begin
      ctr_event = 2'b10; tick();
      ctr_event = 2'b00; tick();
    end
    rd(4'd5, 32'd5, "ctr1_five");
    ctr_event = 2'b11;
    wr(4'd3, 32'h1);
    ctr_event = 2'b00;
    rd(4'd4, 32'd0, "ctr0_cleared");
    rd(4'd5, 32'd0, "ctr1_cleared");
    rd(4'd4, 32'd2, "ctr0_after_clr");

    // Wrap and unmapped reads
    dut.g_ctr[0].ctr_q = 32'hFFFF_FFFF;
    tick();
    rd(4'd4, 32'd0, "ctr0_wrap");
    rd(4'd12, 32'd0, "unmapped_12");
    rd(4'd3, 32'd0, "wo_ctrclr_read");

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mmap_io_regs.md
# mmap_io_regs

Parametrised memory-mapped I/O register block between the CPU load/store path and the UART and performance-counter hardware. It provides UART status, an RX byte FIFO with pop-on-read, a TX holding register with a ready/valid handshake, and NUM_CTRS 32-bit event counters that software can clear. Read data is registered, with one-cycle latency, to match the data-memory read path.

## Interface
- RX_DEPTH, 8: RX FIFO depth in bytes; power of two, ≥2.
- NUM_CTRS, 2: number of 32-bit counters, 1..8. Counter 0 is the cycle counter.
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- sel in 4: register word index (map below).
- rd_en in 1: read strobe; registers with side effects act only when this is high.
- wr_en in 1: write strobe.
- wr_data in 32: write data.
- rd_data out 32: read data, valid the cycle after rd_en.
- rx_data in 8: byte from UART receiver.
- rx_valid in 1: rx_data valid.
- rx_ready out 1: FIFO not full.
- tx_data out 8: byte to UART transmitter.
- tx_valid out 1: TX holding register full.
- tx_ready in 1: transmitter accepts a byte.
- ctr_event in NUM_CTRS: increment enables for counters; bit 0 is ignored.

## Operation
- Register map by sel:
  - 0 STATUS (RO): bit0 = !tx_valid; bit1 = RX non-empty; bit2 = RX overflow (sticky); bits[15:8] = RX occupancy; all other bits 0.
  - 1 RXDATA (RO): FIFO head zero-extended; a read pops the head. Reading an empty FIFO returns 0 and does not pop.
  - 2 TXDATA (WO): wr_data[7:0] loads the holding register.
  - 3 CTRCLR (WO): any write clears all counters.
  - 4+i CTR[i] (RO), for i < NUM_CTRS.
- Unmapped reads return 0. Writes to RO or unmapped registers are ignored.
- RX push: occurs when rx_valid && rx_ready.
  - rx_valid while full: byte dropped, overflow bit set.
  - A read of STATUS returns the overflow bit and clears it in the same cycle. A set event in that same cycle wins.
  - Push and pop in the same cycle: occupancy unchanged. rx_ready depends on the registered full flag only, so a pop while full does not admit a push that cycle.
- TX handshake:
  - tx_valid stays high until tx_valid && tx_ready.
  - A TXDATA write while full is dropped, unless a handshake completes in that cycle; then the new byte is loaded and tx_valid stays high.
  - tx_data is stable while tx_valid is high.
- Counters:
  - CTR[0] increments every cycle.
  - CTR[i] (i≥1) increments on cycles where ctr_event[i] is high.
  - Counters wrap modulo 2^32.
  - A CTRCLR write beats a same-cycle increment: the value becomes 0.
- Reset: FIFO empty, overflow 0, tx_valid 0, tx_data 0, counters 0, rd_data 0. As outputs: rx_ready=1, tx_valid=0, rd_data=0.
- Reset mid-operation flushes buffered RX and TX bytes; nothing is preserved.

## Timing
- Read latency is 1 cycle. rd_data holds its last value when rd_en is low.
- Counter reads return the pre-increment value of the read cycle.
- RXDATA read: data is the head at the rd_en cycle. Occupancy and STATUS reflect the pop from the next cycle.
- Write effects are visible to a read issued the following cycle.
- rd_en and wr_en in the same cycle are legal and act independently.
- rx_ready and tx_valid are registered-state outputs with no combinational path from inputs.

## Structure
- Package mmap_io_pkg holds:
  - register index constants (REG_STATUS=0, REG_RXDATA=1, REG_TXDATA=2, REG_CTRCLR=3, REG_CTR_BASE=4);
  - STATUS bit positions;
  - the MAX_CTRS=8 limit.
- Sub-module io_byte_fifo (parametrised by DEPTH) implements the RX FIFO:
  - ports: push, pop, din, dout, full, empty, count;
  - count is $clog2(DEPTH)+1 bits, zero-extended into STATUS[15:8].
- Counters use a generate loop. The read mux is a single registered case on sel.

## Test plan
- Reset, then read STATUS → 0x00000001; read CTR[0] at the Nth post-reset read cycle → N-1; rx_ready=1, tx_valid=0.
- Push 0x41, 0x42, 0x43 → STATUS bits[15:8]=3, bit1=1; three RXDATA reads → 0x41, 0x42, 0x43; a fourth read → 0, STATUS=0x00000001.
- Push 9 bytes with RX_DEPTH=8 → 9th dropped, rx_ready=0 after 8; STATUS read → bit2=1; next STATUS read → bit2=0.
- Write TXDATA 0x55 with tx_ready=0 → tx_valid=1, tx_data=0x55; write 0x66 → dropped; raise tx_ready and write 0x77 in the same cycle → next cycle tx_data=0x77, tx_valid=1.
- Pulse ctr_event[1] 5 times → CTR[1]=5; write CTRCLR in the same cycle as an event → CTR[0]=CTR[1]=0 next cycle.
- Force CTR[0] to 0xFFFFFFFF (via hierarchical deposit) → next cycle reads 0 (wrap); read sel=12 → 0.
